// File: rtl/reg_readout_ctrl.sv
// Snapshots a register word on request and streams it out as BEAT_W-bit beats over
// valid/ready, then pulses rd_done for one cycle.
module reg_readout_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BEAT_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] reg_data,
  output logic              rd_busy,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_done
);

  localparam int unsigned NBEATS = DATA_W / BEAT_W;
  localparam int unsigned IdxW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBEATS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] shadow_q;

  // The shadow is shifted on each accepted beat so the current beat always sits at one end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_req) begin
            shadow_q <= reg_data;
            idx_q    <= '0;
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q    <= idx_q + 1'b1;
              shadow_q <= MSB_FIRST ? (shadow_q << BEAT_W) : (shadow_q >> BEAT_W);
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == StSend);
    rd_busy   = (state_q != StIdle);
    rd_done   = (state_q == StDone);
    out_data  = '0;
    if (state_q == StSend) begin
      out_data = MSB_FIRST ? shadow_q[DATA_W-1 -: BEAT_W] : shadow_q[BEAT_W-1:0];
    end
  end

endmodule

// File: tb/tb_reg_readout_ctrl.sv
// Bench for reg_readout_ctrl: MSB-first and LSB-first instances driven in parallel,
// compared each cycle against a queue-based beat model.
module tb_reg_readout_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned NB     = DATA_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [DATA_W-1:0] reg_data = '0;
  logic              out_ready = 1'b0;

  logic              busy_m, valid_m, done_m;
  logic [BEAT_W-1:0] data_m;
  logic              busy_l, valid_l, done_l;
  logic [BEAT_W-1:0] data_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending beats per instance plus a flag for the done cycle.
  logic [BEAT_W-1:0] qm[$];
  logic [BEAT_W-1:0] ql[$];
  bit                done_pend = 1'b0;

  always #5 clk = ~clk;

  reg_readout_ctrl #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .rd_req(rd_req), .reg_data(reg_data),
    .rd_busy(busy_m), .out_data(data_m), .out_valid(valid_m),
    .out_ready(out_ready), .rd_done(done_m)
  );

  reg_readout_ctrl #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .rd_req(rd_req), .reg_data(reg_data),
    .rd_busy(busy_l), .out_data(data_l), .out_valid(valid_l),
    .out_ready(out_ready), .rd_done(done_l)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic q, input logic [DATA_W-1:0] d,
                            input logic rdy);
    logic [DATA_W-1:0] tmp;
    if (r) begin
      qm.delete();
      ql.delete();
      done_pend = 1'b0;
    end else if (done_pend) begin
      done_pend = 1'b0;
    end else if (qm.size() > 0) begin
      if (rdy) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
        if (qm.size() == 0) done_pend = 1'b1;
      end
    end else if (q) begin
      for (int k = 0; k < NB; k++) begin
        tmp = d >> (DATA_W - BEAT_W * (k + 1));
        qm.push_back(tmp[BEAT_W-1:0]);
        tmp = d >> (BEAT_W * k);
        ql.push_back(tmp[BEAT_W-1:0]);
      end
    end
  endtask

  task automatic check_outputs();
    logic              ev, eb;
    logic [BEAT_W-1:0] edm, edl;
    ev  = (qm.size() > 0);
    eb  = ev || done_pend;
    edm = ev ? qm[0] : '0;
    edl = ev ? ql[0] : '0;
    check_eq("valid_m", 16'(valid_m), 16'(ev));
    check_eq("data_m",  16'(data_m),  16'(edm));
    check_eq("busy_m",  16'(busy_m),  16'(eb));
    check_eq("done_m",  16'(done_m),  16'(done_pend));
    check_eq("valid_l", 16'(valid_l), 16'(ev));
    check_eq("data_l",  16'(data_l),  16'(edl));
    check_eq("busy_l",  16'(busy_l),  16'(eb));
    check_eq("done_l",  16'(done_l),  16'(done_pend));
  endtask

  // Inputs applied away from the edge, model advanced at the edge, outputs checked at negedge.
  task automatic step(input logic r, input logic q, input logic [DATA_W-1:0] d, input logic rdy);
    rst       = r;
    rd_req    = q;
    reg_data  = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge(r, q, d, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 16'hABCD, 1'b1);

    // Basic readout with ready held high.
    step(1'b0, 1'b1, 16'h00FE, 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Backpressure on the first beat.
    step(1'b0, 1'b1, 16'h0FE6, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Register changes after capture must not leak into the beats.
    step(1'b0, 1'b1, 16'h0FE6, 1'b1);
    repeat (4) step(1'b0, 1'b0, 16'hFFFF, 1'b1);

    // Continuous request: back-to-back readouts with changing data.
    repeat (12) step(1'b0, 1'b1, DATA_W'($urandom), 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b1);

    // Reset after the first beat is accepted aborts without rd_done.
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
           DATA_W'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
